// File: rtl/toggle_rate_monitor_if.sv
// Bundle for toggle_rate_monitor: lane inputs, control and result signals.
// master drives lanes/start/lane_sel; slave is the monitor side.
interface toggle_rate_monitor_if #(
  parameter int LANES       = 8,
  parameter int WINDOW_LOG2 = 16
);
  localparam int SW = $clog2(LANES);

  logic [LANES-1:0]       sig_in;
  logic                   start;
  logic [SW-1:0]          lane_sel;
  logic                   busy;
  logic                   done;
  logic [LANES-1:0]       mismatch;
  logic                   any_mismatch;
  logic [WINDOW_LOG2-1:0] count_out;

  modport master (
    output sig_in, start, lane_sel,
    input  busy, done, mismatch, any_mismatch, count_out
  );

  modport slave (
    input  sig_in, start, lane_sel,
    output busy, done, mismatch, any_mismatch, count_out
  );
endinterface

// File: rtl/toggle_rate_monitor.sv
// Multi-lane rising-edge rate checker against lane 0 over a 2^WINDOW_LOG2 window.
// Define TOGGLE_RATE_MONITOR_CONTINUOUS_EN for back-to-back windows after one start.
module toggle_rate_monitor #(
  parameter int LANES       = 8,
  parameter int WINDOW_LOG2 = 16,
  parameter int TOL         = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  toggle_rate_monitor_if.slave bus
);
  localparam int SW = $clog2(LANES);
  localparam int CW = WINDOW_LOG2;
  localparam logic [2:0]    ARM_LAST = 3'(SYNC_STAGES);
  localparam logic [SW-1:0] CMP_LAST = SW'(LANES - 1);
  localparam logic [CW:0]   TOL_V    = (CW + 1)'(TOL);

`ifdef TOGGLE_RATE_MONITOR_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, ARM, MEASURE, COMPARE, DONE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_q [LANES];
  logic [LANES-1:0] synced;
  logic [LANES-1:0] delayed;
  logic [LANES-1:0] rise;

  logic [CW-1:0]    cnt [LANES];
  logic [CW-1:0]    win;
  logic [2:0]       arm_cnt;
  logic [SW-1:0]    cmp_idx;
  logic             busy_q;
  logic             done_q;
  logic [LANES-1:0] mis_q;
  logic             any_q;

  logic [CW:0]      diff;
  logic [CW:0]      mag;
  logic             mis_bit;
  logic [LANES-1:0] mis_nxt;
  logic             arm_go;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      synced[i] = sync_q[i][SYNC_STAGES-1];
    end
    rise = synced & ~delayed;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) sync_q[i] <= '0;
      delayed <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.sig_in[i]};
      end
      delayed <= synced;
    end
  end

  // Extra top bit keeps the signed difference honest before taking magnitude
  always_comb begin
    diff    = {1'b0, cnt[cmp_idx]} - {1'b0, cnt[0]};
    mag     = diff[CW] ? -diff : diff;
    mis_bit = (cmp_idx != '0) && (mag > TOL_V);
    mis_nxt = mis_q;
    mis_nxt[cmp_idx] = mis_bit;
  end

  always_comb begin
    arm_go = 1'b0;
    unique case (1'b1)
      state == IDLE: arm_go = bus.start;
      state == DONE: arm_go = CONT;
      default:       arm_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      win     <= '0;
      arm_cnt <= '0;
      cmp_idx <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          busy_q <= 1'b0;
        end
        ARM: begin
          if (arm_cnt == ARM_LAST) begin
            state <= MEASURE;
            win   <= '0;
          end else begin
            arm_cnt <= arm_cnt + 3'd1;
          end
        end
        MEASURE: begin
          for (int i = 0; i < LANES; i++) begin
            if (rise[i] && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
          end
          win <= win + 1'b1;
          if (&win) begin
            state   <= COMPARE;
            cmp_idx <= '0;
          end
        end
        COMPARE: begin
          mis_q <= mis_nxt;
          if (cmp_idx == CMP_LAST) begin
            state  <= DONE;
            done_q <= 1'b1;
            any_q  <= |mis_nxt;
            busy_q <= CONT;
          end else begin
            cmp_idx <= cmp_idx + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Entering ARM wipes the previous results
      if (arm_go) begin
        state   <= ARM;
        busy_q  <= 1'b1;
        arm_cnt <= '0;
        mis_q   <= '0;
        any_q   <= 1'b0;
        for (int i = 0; i < LANES; i++) cnt[i] <= '0;
      end
    end
  end

  logic [CW-1:0] cnt_pad [2**SW];

  for (genvar g = 0; g < 2**SW; g++) begin : g_pad
    if (g < LANES) begin : g_on
      assign cnt_pad[g] = cnt[g];
    end else begin : g_off
      assign cnt_pad[g] = '0;
    end
  end

  assign bus.count_out    = cnt_pad[bus.lane_sel];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mismatch     = mis_q;
  assign bus.any_mismatch = any_q;
endmodule
